// File: rtl/led_shifter.sv
// -----------------------------------------------------------------------------
// led_shifter
//   Reader side of the current-frame buffer. On a frame tick it walks every
//   channel address from the highest down to 0, fetches each c_bpc-bit value
//   from the current RAM (one cycle read latency), and shifts it MSB-first onto
//   the LED-driver daisy chain. After the last channel it strobes the driver
//   latch, then pulses o_drq so the animator can compute the next frame.
//
// Ports
//   i_clk    system clock, rising edge
//   i_rstn   asynchronous active-low reset
//   i_start  frame tick, only honoured while idle
//   i_data   current RAM read data, valid one cycle after o_addr
//   o_addr   current RAM read address
//   o_sclk   driver shift clock
//   o_sdata  driver serial data, held stable while o_sclk is high
//   o_latch  driver latch strobe
//   o_busy   high from the cycle after an accepted start until back in idle
//   o_drq    one-cycle pulse once the frame has been latched
// -----------------------------------------------------------------------------
module led_shifter #(
  parameter int c_ledboards = 30,
  parameter int c_channels  = c_ledboards * 32,
  parameter int c_addr_w    = $clog2(c_channels),
  parameter int c_bpc       = 12,
  parameter int c_clkdiv    = 4
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_start,
  input  logic [c_bpc-1:0]    i_data,
  output logic [c_addr_w-1:0] o_addr,
  output logic                o_sclk,
  output logic                o_sdata,
  output logic                o_latch,
  output logic                o_busy,
  output logic                o_drq
);

  localparam int DIV_W = (c_clkdiv > 1) ? $clog2(c_clkdiv) : 1;
  localparam int BIT_W = $clog2(c_bpc + 1);

  localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(c_clkdiv - 1);
  localparam logic [DIV_W-1:0]    DIV_ONE   = DIV_W'(1);
  localparam logic [BIT_W-1:0]    BIT_FULL  = BIT_W'(c_bpc);
  localparam logic [BIT_W-1:0]    BIT_ONE   = BIT_W'(1);
  localparam logic [c_addr_w-1:0] ADDR_LAST = c_addr_w'(c_channels - 1);
  localparam logic [c_addr_w-1:0] ADDR_ONE  = c_addr_w'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHIFT,
    S_LATCH,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [c_addr_w-1:0] addr_q;
  logic                sclk_q;
  logic                sdata_q;
  logic                latch_q;
  logic                busy_q;
  logic                drq_q;
  logic [DIV_W-1:0]    divcnt_q;
  logic [BIT_W-1:0]    bitcnt_q;
  // The MSB of each word goes straight from i_data to o_sdata at load time,
  // so the shift register only has to hold the remaining c_bpc-1 bits.
  logic [c_bpc-2:0]    shreg_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
      latch_q  <= 1'b0;
      busy_q   <= 1'b0;
      drq_q    <= 1'b0;
      divcnt_q <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
    end else begin
      drq_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            addr_q  <= ADDR_LAST;
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
          end
        end

        // Address is on the RAM port this cycle; data arrives next cycle.
        S_FETCH: begin
          state_q <= S_LOAD;
        end

        S_LOAD: begin
          shreg_q  <= i_data[c_bpc-2:0];
          sdata_q  <= i_data[c_bpc-1];
          bitcnt_q <= BIT_FULL;
          divcnt_q <= '0;
          state_q  <= S_SHIFT;
        end

        // divcnt_q times each half-period; sclk_q tells which half we are in.
        // Data only moves when the high half ends, so o_sdata is never
        // disturbed while o_sclk is high.
        S_SHIFT: begin
          if (divcnt_q != DIV_LAST) begin
            divcnt_q <= divcnt_q + DIV_ONE;
          end else begin
            divcnt_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q   <= 1'b0;
              sdata_q  <= shreg_q[c_bpc-2];
              shreg_q  <= shreg_q << 1;
              bitcnt_q <= bitcnt_q - BIT_ONE;
              if (bitcnt_q == BIT_ONE) begin
                // Address 0 is shifted last so it ends up in the nearest board.
                if (addr_q == '0) begin
                  latch_q <= 1'b1;
                  state_q <= S_LATCH;
                end else begin
                  addr_q  <= addr_q - ADDR_ONE;
                  state_q <= S_FETCH;
                end
              end
            end
          end
        end

        // Latch held for one full half-period with sclk low.
        S_LATCH: begin
          if (divcnt_q != DIV_LAST) begin
            divcnt_q <= divcnt_q + DIV_ONE;
          end else begin
            divcnt_q <= '0;
            latch_q  <= 1'b0;
            drq_q    <= 1'b1;
            state_q  <= S_DONE;
          end
        end

        // o_drq is high during this cycle; busy drops as we return to idle,
        // so a start coincident with o_drq is not seen.
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_addr  = addr_q;
  assign o_sclk  = sclk_q;
  assign o_sdata = sdata_q;
  assign o_latch = latch_q;
  assign o_busy  = busy_q;
  assign o_drq   = drq_q;

endmodule
